// File: rtl/icache_tag_req_issue_if.sv
// Request channel shared by the upstream, prefetch and downstream sources:
// valid/ready handshake carrying an address and a transaction id.
interface icache_tag_req_issue_if #(
    parameter int ADDR_W  = 32,
    parameter int TXNID_W = 4
);
    logic               vld;
    logic               rdy;
    logic [ADDR_W-1:0]  addr;
    logic [TXNID_W-1:0] txnid;

    modport master (output vld, addr, txnid, input rdy);
    modport slave  (input vld, addr, txnid, output rdy);
endinterface

// File: rtl/icache_tag_req_issue.sv
// Arbitrates dn/up/pf requests into a single outstanding tag-array lookup and
// returns the sampled result. Define ICACHE_TAG_ISSUE_RR_EN for round-robin arbitration.
module icache_tag_req_issue #(
    parameter int RESP_LAT                = 1,
    parameter int ICACHE_REQ_ADDR_WIDTH   = 32,
    parameter int ICACHE_REQ_TXNID_WIDTH  = 4,
    parameter int ICACHE_REQ_OPCODE_WIDTH = 2,
    parameter int WAY_NUM                 = 2,
    parameter logic [ICACHE_REQ_OPCODE_WIDTH-1:0] UPSTREAM_OPCODE   = ICACHE_REQ_OPCODE_WIDTH'(2'd1),
    parameter logic [ICACHE_REQ_OPCODE_WIDTH-1:0] PREFETCH_OPCODE   = ICACHE_REQ_OPCODE_WIDTH'(2'd2),
    parameter logic [ICACHE_REQ_OPCODE_WIDTH-1:0] DOWNSTREAM_OPCODE = ICACHE_REQ_OPCODE_WIDTH'(2'd3)
) (
    input  logic                               clk,
    input  logic                               rst,
    icache_tag_req_issue_if.slave              up_req,
    icache_tag_req_issue_if.slave              pf_req,
    icache_tag_req_issue_if.slave              dn_req,
    output logic                               tag_req_vld,
    output logic [ICACHE_REQ_ADDR_WIDTH-1:0]   tag_req_addr,
    output logic [ICACHE_REQ_OPCODE_WIDTH-1:0] tag_req_opcode,
    output logic [ICACHE_REQ_TXNID_WIDTH-1:0]  tag_req_txnid,
    input  logic [WAY_NUM-1:0]                 tag_hit,
    input  logic                               tag_miss,
    input  logic                               lru_pick,
    input  logic                               tagram_req_rdy,
    output logic                               stall,
    output logic                               rsp_vld,
    input  logic                               rsp_rdy,
    output logic                               rsp_hit,
    output logic [WAY_NUM-1:0]                 rsp_way,
    output logic                               rsp_victim,
    output logic [ICACHE_REQ_OPCODE_WIDTH-1:0] rsp_opcode,
    output logic [ICACHE_REQ_TXNID_WIDTH-1:0]  rsp_txnid,
    output logic [ICACHE_REQ_ADDR_WIDTH-1:0]   rsp_addr
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP, S_BUBBLE} state_e;

    state_e                               state_q, state_d;
    logic [2:0]                           cnt_q, cnt_d;
    logic [ICACHE_REQ_ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0]    txnid_q, txnid_d;
    logic [ICACHE_REQ_OPCODE_WIDTH-1:0]   opc_q, opc_d;
    logic [WAY_NUM-1:0]                   hit_q, hit_d;
    logic                                 miss_q, miss_d;
    logic                                 lru_q, lru_d;
    logic                                 wr_q, wr_d;
    logic                                 init_q;
    logic [2:0]                           vld_s, grant_s, rdy_s;
    logic                                 open_s, accept_s, tag_vld_s, rsp_vld_s;

    // Bit 0 = dn, 1 = up, 2 = pf; first requester found starting at index `first`.
    function automatic logic [2:0] pick_winner(input logic [2:0] v, input logic [1:0] first);
        logic [5:0] rot_s;
        logic [2:0] g_s;
        rot_s = {v, v} >> first;
        if (rot_s[0])      g_s = 3'b001;
        else if (rot_s[1]) g_s = 3'b010;
        else if (rot_s[2]) g_s = 3'b100;
        else               g_s = 3'b000;
        rot_s = {g_s, g_s} << first;
        return rot_s[5:3];
    endfunction

    assign vld_s    = {pf_req.vld, up_req.vld, dn_req.vld};
    // init_q keeps every ready low for the first cycle after reset.
    assign open_s   = (state_q == S_IDLE) && !init_q && !rst;
    assign rdy_s    = grant_s & {3{open_s}};
    assign accept_s = |(rdy_s & vld_s);

    assign dn_req.rdy = rdy_s[0];
    assign up_req.rdy = rdy_s[1];
    assign pf_req.rdy = rdy_s[2];

`ifdef ICACHE_TAG_ISSUE_RR_EN
    logic [1:0] ptr_q, ptr_d;

    // Round-robin pointer advances past the winner on every accept.
    always_comb begin
        ptr_d = ptr_q;
        if (accept_s) begin
            case (grant_s)
                3'b001:  ptr_d = 2'd1;
                3'b010:  ptr_d = 2'd2;
                3'b100:  ptr_d = 2'd0;
                default: ptr_d = ptr_q;
            endcase
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end

    // Winner selection from the round-robin pointer.
    always_comb begin
        grant_s = pick_winner(vld_s, ptr_q);
    end
`else
    // Fixed priority dn > up > pf.
    always_comb begin
        grant_s = pick_winner(vld_s, 2'd0);
    end
`endif

    // Next-state logic: capture winner, count lookup latency, sample result, release.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        txnid_d = txnid_q;
        opc_d   = opc_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        lru_d   = lru_q;
        wr_d    = wr_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    cnt_d   = 3'd1;
                    state_d = S_ISSUE;
                    if (grant_s[0]) begin
                        addr_d = dn_req.addr; txnid_d = dn_req.txnid; opc_d = DOWNSTREAM_OPCODE;
                    end else if (grant_s[1]) begin
                        addr_d = up_req.addr; txnid_d = up_req.txnid; opc_d = UPSTREAM_OPCODE;
                    end else begin
                        addr_d = pf_req.addr; txnid_d = pf_req.txnid; opc_d = PREFETCH_OPCODE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (cnt_q == 3'(RESP_LAT)) begin
                    hit_d   = tag_hit;
                    miss_d  = tag_miss;
                    lru_d   = lru_pick;
                    wr_d    = tagram_req_rdy;
                    cnt_d   = 3'd0;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_RESP: begin
                if (rsp_rdy) state_d = wr_q ? S_BUBBLE : S_IDLE;
                else         state_d = S_RESP;
            end
            S_BUBBLE: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= {ICACHE_REQ_ADDR_WIDTH{1'b0}};
            txnid_q <= {ICACHE_REQ_TXNID_WIDTH{1'b0}};
            opc_q   <= {ICACHE_REQ_OPCODE_WIDTH{1'b0}};
            hit_q   <= {WAY_NUM{1'b0}};
            miss_q  <= 1'b0;
            lru_q   <= 1'b0;
            wr_q    <= 1'b0;
            init_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            txnid_q <= txnid_d;
            opc_q   <= opc_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            lru_q   <= lru_d;
            wr_q    <= wr_d;
            init_q  <= 1'b0;
        end
    end

    assign tag_vld_s      = (state_q == S_ISSUE) && !rst;
    assign rsp_vld_s      = (state_q == S_RESP) && !rst;
    assign tag_req_vld    = tag_vld_s;
    assign tag_req_addr   = tag_vld_s ? addr_q  : {ICACHE_REQ_ADDR_WIDTH{1'b0}};
    assign tag_req_opcode = tag_vld_s ? opc_q   : {ICACHE_REQ_OPCODE_WIDTH{1'b0}};
    assign tag_req_txnid  = tag_vld_s ? txnid_q : {ICACHE_REQ_TXNID_WIDTH{1'b0}};
    assign stall          = rsp_vld_s && !rsp_rdy;
    assign rsp_vld        = rsp_vld_s;
    // A simultaneous miss overrides any hit way.
    assign rsp_hit        = rsp_vld_s && (|hit_q) && !miss_q;
    assign rsp_way        = rsp_vld_s ? hit_q   : {WAY_NUM{1'b0}};
    assign rsp_victim     = rsp_vld_s && lru_q;
    assign rsp_opcode     = rsp_vld_s ? opc_q   : {ICACHE_REQ_OPCODE_WIDTH{1'b0}};
    assign rsp_txnid      = rsp_vld_s ? txnid_q : {ICACHE_REQ_TXNID_WIDTH{1'b0}};
    assign rsp_addr       = rsp_vld_s ? addr_q  : {ICACHE_REQ_ADDR_WIDTH{1'b0}};
endmodule

// File: tb/tb_icache_tag_req_issue.sv
// Random-stimulus bench: scoreboard queue of accepted requests against a
// cycle-level model of arbitration, lookup latency, stall and bubble.
module tb_icache_tag_req_issue;
    localparam int RESP_LAT = 3;
    localparam int AW = 32;
    localparam int TW = 4;
    localparam int OW = 2;
    localparam int WN = 2;
    localparam int NCYC = 4000;
    localparam logic [1:0] UP_OPC = 2'd1;
    localparam logic [1:0] PF_OPC = 2'd2;
    localparam logic [1:0] DN_OPC = 2'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_tag_req_issue_if #(.ADDR_W(AW), .TXNID_W(TW)) up_if ();
    icache_tag_req_issue_if #(.ADDR_W(AW), .TXNID_W(TW)) pf_if ();
    icache_tag_req_issue_if #(.ADDR_W(AW), .TXNID_W(TW)) dn_if ();

    logic          tag_req_vld, tag_miss, lru_pick, tagram_req_rdy, stall;
    logic [AW-1:0] tag_req_addr, rsp_addr;
    logic [OW-1:0] tag_req_opcode, rsp_opcode;
    logic [TW-1:0] tag_req_txnid, rsp_txnid;
    logic [WN-1:0] tag_hit, rsp_way;
    logic          rsp_vld, rsp_rdy, rsp_hit, rsp_victim;

    icache_tag_req_issue #(
        .RESP_LAT(RESP_LAT), .ICACHE_REQ_ADDR_WIDTH(AW), .ICACHE_REQ_TXNID_WIDTH(TW),
        .ICACHE_REQ_OPCODE_WIDTH(OW), .WAY_NUM(WN),
        .UPSTREAM_OPCODE(UP_OPC), .PREFETCH_OPCODE(PF_OPC), .DOWNSTREAM_OPCODE(DN_OPC)
    ) dut (
        .clk(clk), .rst(rst),
        .up_req(up_if), .pf_req(pf_if), .dn_req(dn_if),
        .tag_req_vld(tag_req_vld), .tag_req_addr(tag_req_addr),
        .tag_req_opcode(tag_req_opcode), .tag_req_txnid(tag_req_txnid),
        .tag_hit(tag_hit), .tag_miss(tag_miss), .lru_pick(lru_pick),
        .tagram_req_rdy(tagram_req_rdy), .stall(stall),
        .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .rsp_victim(rsp_victim), .rsp_opcode(rsp_opcode), .rsp_txnid(rsp_txnid),
        .rsp_addr(rsp_addr)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [TW-1:0] txn;
        logic [OW-1:0] opc;
        int            acc;
    } item_t;

    item_t         sb_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            idle_from = 0;
    int            rr_ptr = 0;
    // Source index 0 = dn, 1 = up, 2 = pf.
    logic          pend[3];
    logic [AW-1:0] s_addr[3];
    logic [TW-1:0] s_txn[3];
    logic          acc_flag[3];
    logic [WN-1:0] h_hit[NCYC+16];
    logic          h_miss[NCYC+16];
    logic          h_lru[NCYC+16];
    logic          h_wr[NCYC+16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d act=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic drive_srcs();
        dn_if.vld = pend[0]; dn_if.addr = s_addr[0]; dn_if.txnid = s_txn[0];
        up_if.vld = pend[1]; up_if.addr = s_addr[1]; up_if.txnid = s_txn[1];
        pf_if.vld = pend[2]; pf_if.addr = s_addr[2]; pf_if.txnid = s_txn[2];
    endtask

    // Monitor / reference model, sampled mid-cycle.
    initial begin
        logic          exp_rv, exp_tv, tr;
        logic [2:0]    exp_g, dut_g;
        logic [41:0]   exp_rsp, dut_rsp;
        logic [37:0]   exp_tag, dut_tag;
        logic [OW-1:0] opc_tab[3];
        int            w, idx, sidx;
        opc_tab[0] = DN_OPC; opc_tab[1] = UP_OPC; opc_tab[2] = PF_OPC;
        forever begin
            @(negedge clk);
            h_hit[cyc] = tag_hit; h_miss[cyc] = tag_miss;
            h_lru[cyc] = lru_pick; h_wr[cyc] = tagram_req_rdy;
            dut_g   = {pf_if.rdy, up_if.rdy, dn_if.rdy};
            dut_rsp = {rsp_hit, rsp_way, rsp_victim, rsp_opcode, rsp_txnid, rsp_addr};
            dut_tag = {tag_req_opcode, tag_req_txnid, tag_req_addr};
            if (rst) begin
                chk("reset_outputs", {24'd0, dut_g, tag_req_vld, rsp_vld, stall, dut_rsp[41:38], dut_tag[37:32]},
                    64'd0);
                chk("reset_data", {dut_rsp[31:0], dut_tag[31:0]}, 64'd0);
                sb_q.delete();
                idle_from = cyc + 2;
                rr_ptr = 0;
            end else begin
                exp_rv = (sb_q.size() > 0) && (cyc >= sb_q[0].acc + RESP_LAT + 1);
                exp_tv = (sb_q.size() > 0) && (cyc >= sb_q[0].acc + 1) && (cyc <= sb_q[0].acc + RESP_LAT);
                chk("rsp_vld", 64'(rsp_vld), 64'(exp_rv));
                chk("tag_req_vld", 64'(tag_req_vld), 64'(exp_tv));
                chk("stall", 64'(stall), 64'(exp_rv && !rsp_rdy));
                exp_tag = exp_tv ? {sb_q[0].opc, sb_q[0].txn, sb_q[0].addr} : 38'd0;
                chk("tag_req_fields", 64'(dut_tag), 64'(exp_tag));
                exp_rsp = 42'd0;
                tr = 1'b0;
                if (exp_rv) begin
                    sidx = sb_q[0].acc + RESP_LAT;
                    tr = h_wr[sidx];
                    exp_rsp = {(h_hit[sidx] != 2'b00) && !h_miss[sidx], h_hit[sidx], h_lru[sidx],
                               sb_q[0].opc, sb_q[0].txn, sb_q[0].addr};
                end
                chk("rsp_fields", 64'(dut_rsp), 64'(exp_rsp));
                exp_g = 3'b000;
                w = -1;
                if (sb_q.size() == 0 && cyc >= idle_from) begin
                    for (int k = 0; k < 3; k++) begin
                        idx = (rr_ptr + k) % 3;
                        if (w < 0 && pend[idx]) w = idx;
                    end
                    if (w >= 0) exp_g[w] = 1'b1;
                end
                chk("grant", 64'(dut_g), 64'(exp_g));
                if (w >= 0) begin
                    sb_q.push_back('{addr: s_addr[w], txn: s_txn[w], opc: opc_tab[w], acc: cyc});
                    acc_flag[w] = 1'b1;
`ifdef ICACHE_TAG_ISSUE_RR_EN
                    rr_ptr = (w + 1) % 3;
`endif
                end
                if (exp_rv && rsp_rdy) begin
                    void'(sb_q.pop_front());
                    idle_from = cyc + (tr ? 2 : 1);
                end
            end
            cyc++;
        end
    end

    // Stimulus: sources hold vld until accepted; lookup results and rsp_rdy random.
    initial begin
        for (int s = 0; s < 3; s++) begin
            pend[s] = 1'b0; s_addr[s] = '0; s_txn[s] = '0; acc_flag[s] = 1'b0;
        end
        drive_srcs();
        tag_hit = 2'b00; tag_miss = 1'b0; lru_pick = 1'b0; tagram_req_rdy = 1'b0; rsp_rdy = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        for (int n = 0; n < NCYC - 8; n++) begin
            @(posedge clk);
            #1;
            for (int s = 0; s < 3; s++) begin
                if (acc_flag[s]) begin
                    pend[s] = 1'b0;
                    acc_flag[s] = 1'b0;
                end
                if (!pend[s] && ($urandom % 3 == 0)) begin
                    pend[s] = 1'b1;
                    s_addr[s] = $urandom;
                    s_txn[s] = 4'($urandom);
                end
            end
            drive_srcs();
            tag_hit = 2'($urandom);
            tag_miss = ($urandom % 3 == 0);
            lru_pick = 1'($urandom);
            tagram_req_rdy = 1'($urandom);
            rsp_rdy = ($urandom % 4 != 0);
            rst = ($urandom % 250 == 0);
        end
        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/icache_tag_req_issue.md
ICACHE_TAG_REQ_ISSUE -- requirements
Module: icache_tag_req_issue

Interface
REQ-001 Parameter RESP_LAT, 1, cycles from first tag_req_vld cycle to the cycle tag_hit/tag_miss/lru_pick are sampled; legal 1..7.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 up_req_vld/up_req_rdy  input/output  1/1  upstream fetch handshake; up_req_addr input req_addr_t; up_req_txnid input ICACHE_REQ_TXNID_WIDTH.
REQ-005 pf_req_vld/pf_req_rdy, pf_req_addr, pf_req_txnid: prefetch source, same widths as REQ-004.
REQ-006 dn_req_vld/dn_req_rdy, dn_req_addr, dn_req_txnid: downstream (linefill/invalidate) source, same widths as REQ-004.
REQ-007 tag_req_vld  output  1; tag_req_addr output req_addr_t; tag_req_opcode output ICACHE_REQ_OPCODE_WIDTH; tag_req_txnid output ICACHE_REQ_TXNID_WIDTH: request to tag array control.
REQ-008 tag_hit  input  WAY_NUM; tag_miss input 1; lru_pick input 1: tag lookup result.
REQ-009 tagram_req_rdy  input  1  high in the sampled result cycle means the tag array performs a write that cycle.
REQ-010 stall  output  1  freezes tag array control while a result is held un-accepted.
REQ-011 rsp_vld output 1, rsp_rdy input 1, rsp_hit output 1, rsp_way output WAY_NUM, rsp_victim output 1, rsp_opcode output ICACHE_REQ_OPCODE_WIDTH, rsp_txnid output ICACHE_REQ_TXNID_WIDTH, rsp_addr output req_addr_t: lookup result to miss/data path.

Function
REQ-012 Exactly one request outstanding; FSM states IDLE, ISSUE, RESP, BUBBLE.
REQ-013 IDLE: x_req_rdy high only for the arbitration winner (REQ-020/REQ-030); on winner vld&&rdy latch addr/txnid, set opcode DOWNSTREAM_OPCODE/UPSTREAM_OPCODE/PREFETCH_OPCODE by source, go ISSUE.
REQ-014 All x_req_rdy low in every state except IDLE.
REQ-015 ISSUE: tag_req_vld=1 with latched addr/opcode/txnid held stable; 3-bit counter counts cycles from 1; at count==RESP_LAT sample tag_hit, tag_miss, lru_pick, tagram_req_rdy into result registers, go RESP.
REQ-016 tag_req_vld deasserts the cycle after sampling; tag_req_* fields zero whenever tag_req_vld low.
REQ-017 RESP: rsp_vld=1, fields = sampled values plus latched opcode/txnid/addr; rsp_hit = |tag_hit && !tag_miss; rsp_way = tag_hit; rsp_victim = lru_pick; fields stable while rsp_vld && !rsp_rdy.
REQ-018 stall = rsp_vld && !rsp_rdy.
REQ-019 RESP on rsp_rdy: go BUBBLE if sampled tagram_req_rdy==1, else IDLE; BUBBLE lasts exactly 1 cycle (all rdy low) then IDLE.
REQ-020 Arbitration (macro undefined): fixed priority dn > up > pf; simultaneous requests grant highest, others wait with vld held.
REQ-021 Minimum accept-to-rsp_vld latency = RESP_LAT+1 cycles (accept edge T, tag_req_vld T+1..T+RESP_LAT, rsp_vld from T+RESP_LAT+1).
REQ-022 Back-to-back throughput with rsp_rdy=1, no bubble: one request per RESP_LAT+2 cycles.
REQ-023 tag_miss and tag_hit both high in sample cycle: rsp_hit=0 (miss wins).

Reset
REQ-024 rst high at any edge: FSM IDLE, counter 0, result registers 0, round-robin pointer to dn; outstanding request dropped without response.
REQ-025 During and the cycle after rst: rsp_vld=0, tag_req_vld=0, stall=0, all x_req_rdy=0, all data outputs 0.

Configuration
REQ-026 Macro ICACHE_TAG_ISSUE_RR_EN selects arbitration.
REQ-027 Undefined: fixed priority per REQ-020.
REQ-028 Defined: round-robin dn->up->pf; pointer moves to source after last winner on each accept; pointer unchanged if no accept.
REQ-029 Ports, latency and all other requirements identical with or without macro.
REQ-030 Defined, all three requesting continuously: grants cycle dn, up, pf, dn, ...

Verification
REQ-031 RESP_LAT=1, up_req addr A txnid 5, tag_hit=2'b01 at sample, rsp_rdy=1 -> rsp_vld 2 cycles after accept, rsp_hit=1, rsp_way=01, rsp_txnid=5, opcode UPSTREAM_OPCODE.
REQ-032 dn, up, pf vld same cycle, macro undefined -> grants dn, up, pf in that order; macro defined, all vld held -> dn, up, pf, dn.
REQ-033 Miss with lru_pick=1, tagram_req_rdy=1, rsp_rdy=0 for 4 cycles -> stall=1 4 cycles, rsp fields stable, rsp_hit=0, rsp_victim=1, one BUBBLE cycle before next up_req_rdy.
REQ-034 RESP_LAT=3 -> tag_req_vld high exactly 3 cycles, sampling on third; rsp_vld 4 cycles after accept.
REQ-035 rst asserted in ISSUE -> next cycle all outputs 0, no rsp_vld for dropped request, next request accepted normally.
